decode38_seq: RTL and testbench
===============================

# decode38_seq

Registered 3-to-8 one-hot decoder with a valid/ready input handshake. It consumes the 3-bit code and all-zero flag produced by the lab's 8-to-3 priority encoder. For each accepted non-zero code it asserts the matching one-hot line for a fixed number of cycles, then pulses `done`. It sits between the encoder stage and the board LED/segment outputs, and also counts all-zero samples.

## Interface

Parameters:
- `HOLD_CYCLES`, default 4: cycles each one-hot output is held; legal range 1..255.

Ports:
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: sender has a sample on `in_code`/`in_nz`.
- `in_ready` output 1: block can accept a sample.
- `in_code` input 3: encoded index, 0..7.
- `in_nz` input 1: 1 = encoder saw at least one set bit; 0 = all-zero input, so `in_code` is meaningless.
- `y` output 8: one-hot decoded output; 8'h00 when idle.
- `y_valid` output 1: `y` is holding a decoded code.
- `done` output 1: one-cycle pulse when a hold period ends.
- `zero_cnt` output 8: count of accepted all-zero samples; saturates at 255.
- `seg` output 7 (only with `DECODE38_SEG_EN`): active-low 7-segment bus, bit order {g,f,e,d,c,b,a}.

## Operation

- Two states, IDLE and HOLD, plus a hold counter `cnt` sized to hold HOLD_CYCLES-1.
- `in_ready` = (state == IDLE). It is a registered-state decode with no combinational path from `in_valid`.
- A sample is accepted on a rising edge where `in_valid && in_ready`.
- IDLE, accepted sample with `in_nz=1`:
  - `y` <= 1 << `in_code`; `y_valid` <= 1.
  - `cnt` <= HOLD_CYCLES-1; state goes to HOLD.
- IDLE, accepted sample with `in_nz=0`:
  - State stays IDLE; `y` stays 8'h00.
  - `zero_cnt` increments, holding at 8'hFF once reached.
  - `done` is not pulsed.
- IDLE, no sample: all outputs hold; `done`=0.
- HOLD:
  - If `cnt`=0: `y` <= 0, `y_valid` <= 0, `done` <= 1, state goes to IDLE.
  - Otherwise `cnt` decrements.
- `in_valid` during HOLD is not accepted. The sender keeps `in_valid`, `in_code` and `in_nz` stable until `in_ready` is high.
- `done` is registered and high for exactly one cycle per completed hold.
- Reset (asynchronous, any state, including mid-hold): state=IDLE, `cnt`=0, `y`=8'h00, `y_valid`=0, `done`=0, `zero_cnt`=0, `in_ready`=1 and `seg`=7'h7F once reset is applied.

## Timing

- Accept edge E: from E, `y`/`y_valid` are valid for exactly HOLD_CYCLES cycles.
- Edge E+HOLD_CYCLES: `y`=0, `y_valid`=0, `done`=1, `in_ready`=1.
- A new sample may be accepted on edge E+HOLD_CYCLES+1, during the `done` cycle. Its `y` then appears immediately after `done` with no gap cycle.
- Maximum throughput: one non-zero code per HOLD_CYCLES+1 cycles.
- All-zero samples can be accepted every cycle while in IDLE.
- HOLD_CYCLES=1: `y_valid` is high for one cycle; `done` follows on the next cycle.
- `zero_cnt` at 255 plus another all-zero sample: stays 255, with no wrap.

## Configuration

- `DECODE38_SEG_EN` defined:
  - The `seg` port exists and is registered alongside `y`.
  - While `y_valid`=1, `seg` shows the held code as a standard hex digit, active-low (0 = 7'b1000000, 7 = 7'b1111000).
  - Otherwise `seg`=7'h7F, all segments off.
- `DECODE38_SEG_EN` undefined: no `seg` port and no segment logic. All other behaviour is identical.

## Test plan

- Reset then idle, HOLD_CYCLES=4: `y`=00, `y_valid`=0, `done`=0, `zero_cnt`=0, `in_ready`=1.
- Accept `in_code`=5, `in_nz`=1 -> `y`=8'h20 for 4 cycles; then `done`=1 for one cycle with `y`=00; `in_ready` low during hold.
- `in_valid` held high with code 3 then code 6, back-to-back -> `y`=8'h08 for 4 cycles, a `done` cycle, then `y`=8'h40 for 4 cycles; code 6 is accepted only on the `done` cycle.
- 260 consecutive samples with `in_nz=0` -> `y` stays 00, no `done`, `zero_cnt`=255 (saturated).
- Accept code 7, then assert `rst_n`=0 after 2 hold cycles -> `y`=00, `y_valid`=0 and `in_ready`=1 immediately, without waiting for a clock edge.
- With `DECODE38_SEG_EN`: code 0 accepted -> `seg`=7'b1000000 during hold; after `done`, `seg`=7'h7F.

Source files
------------

// File: rtl/decode38_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready intake, per-code hold timer and all-zero counter.
// Optional active-low 7-segment output is enabled by defining DECODE38_SEG_EN.
module decode38_seq #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_nz,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       done,
    output logic [7:0] zero_cnt
`ifdef DECODE38_SEG_EN
    ,
    output logic [6:0] seg
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Counter is 8 bits wide so HOLD_CYCLES=1 (reload value 0) still has a legal width.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] y_q, y_d;
    logic       y_valid_q, y_valid_d;
    logic       done_q, done_d;
    logic [7:0] zero_cnt_q, zero_cnt_d;
    logic       accept_s;
    logic       hold_end_s;

    assign accept_s   = in_valid && (state_q == ST_IDLE);
    assign hold_end_s = (state_q == ST_HOLD) && (cnt_q == 8'd0);

    // Next-state and output computation for the IDLE/HOLD controller.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        done_d     = 1'b0;
        zero_cnt_d = zero_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && in_nz) begin
                    y_d       = 8'd1 << in_code;
                    y_valid_d = 1'b1;
                    cnt_d     = HOLD_LAST;
                    state_d   = ST_HOLD;
                end else if (accept_s) begin
                    if (zero_cnt_q != 8'hFF) begin
                        zero_cnt_d = zero_cnt_q + 8'd1;
                    end else begin
                        zero_cnt_d = zero_cnt_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    y_d       = 8'h00;
                    y_valid_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                y_d       = 8'h00;
                y_valid_d = 1'b0;
                cnt_d     = 8'd0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            y_q        <= 8'h00;
            y_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            zero_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            done_q     <= done_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign done     = done_q;
    assign zero_cnt = zero_cnt_q;

`ifdef DECODE38_SEG_EN
    logic [6:0] seg_q, seg_d;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_seg(input logic [2:0] code);
        logic [6:0] pat;
        case (code)
            3'd0:    pat = 7'b1000000;
            3'd1:    pat = 7'b1111001;
            3'd2:    pat = 7'b0100100;
            3'd3:    pat = 7'b0110000;
            3'd4:    pat = 7'b0011001;
            3'd5:    pat = 7'b0010010;
            3'd6:    pat = 7'b0000010;
            3'd7:    pat = 7'b1111000;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // Segment pattern tracks y: loaded on a non-zero accept, blanked when the hold ends.
    always_comb begin
        seg_d = seg_q;
        if (accept_s && in_nz) begin
            seg_d = hex_seg(in_code);
        end else if (hold_end_s) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = seg_q;
        end
    end

    // Segment output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h7F;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
`else
    logic unused_s;
    assign unused_s = hold_end_s;
`endif

endmodule

// File: tb/tb_decode38_seq.sv
// Self-checking bench for decode38_seq: directed scenarios plus random traffic against a
// cycle-level transaction model (remaining-hold-edges count, saturating zero count).
module tb_decode38_seq;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_nz;
    logic [7:0] y;
    logic       y_valid;
    logic       done;
    logic [7:0] zero_cnt;
`ifdef DECODE38_SEG_EN
    logic [6:0] seg;
`endif

    decode38_seq #(.HOLD_CYCLES(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .in_nz    (in_nz),
        .y        (y),
        .y_valid  (y_valid),
        .done     (done),
        .zero_cnt (zero_cnt)
`ifdef DECODE38_SEG_EN
        ,
        .seg      (seg)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: edges left until the hold ends, the held code, and the saturating zero count.
    int         m_left;
    logic [2:0] m_code;
    logic       m_done;
    int         m_zero;

    function automatic logic [6:0] hex7(input logic [2:0] c);
        logic [6:0] t [8];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
        return t[c];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [7:0] ey;
        ey = (m_left > 0) ? (8'd1 << m_code) : 8'h00;
        check({ctx, ".y"},        y,                 ey);
        check({ctx, ".y_valid"},  {7'd0, y_valid},   {7'd0, (m_left > 0)});
        check({ctx, ".done"},     {7'd0, done},      {7'd0, m_done});
        check({ctx, ".zero_cnt"}, zero_cnt,          8'(m_zero));
        check({ctx, ".in_ready"}, {7'd0, in_ready},  {7'd0, (m_left == 0)});
`ifdef DECODE38_SEG_EN
        check({ctx, ".seg"}, {1'b0, seg}, {1'b0, (m_left > 0) ? hex7(m_code) : 7'h7F});
`endif
    endtask

    task automatic model_reset();
        m_left = 0;
        m_code = 3'd0;
        m_done = 1'b0;
        m_zero = 0;
    endtask

    // One clock: drive inputs, advance the model across the edge, check #1 later.
    task automatic step(input string ctx, input logic v, input logic [2:0] c, input logic nz);
        in_valid = v;
        in_code  = c;
        in_nz    = nz;
        @(posedge clk);
        m_done = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (v && nz) begin
            m_left = H;
            m_code = c;
        end else if (v) begin
            m_zero = (m_zero < 255) ? m_zero + 1 : 255;
        end
        #1 check_all(ctx);
    endtask

    initial begin
        logic       pv, pnz, acc;
        logic [2:0] pc;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = 3'd0;
        in_nz    = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 3'd0, 1'b0);

        // Single code 5: four hold cycles then a done cycle.
        step("c5_acc", 1'b1, 3'd5, 1'b1);
        check("c5_y", y, 8'h20);
        for (int i = 0; i < H; i++) step("c5_hold", 1'b0, 3'd0, 1'b0);
        check("c5_done", {7'd0, done}, 8'd1);
        step("c5_after", 1'b0, 3'd0, 1'b0);

        // Back-to-back: valid held through the hold; code 6 taken on the done cycle.
        step("b2b_3", 1'b1, 3'd3, 1'b1);
        for (int i = 0; i < H; i++) step("b2b_w3", 1'b1, 3'd6, 1'b1);
        check("b2b_done", {7'd0, done}, 8'd1);
        step("b2b_6", 1'b1, 3'd6, 1'b1);
        check("b2b_y6", y, 8'h40);
        for (int i = 0; i < H; i++) step("b2b_h6", 1'b0, 3'd0, 1'b0);

        // Zero-count saturation.
        for (int i = 0; i < 260; i++) step("zeros", 1'b1, 3'($urandom_range(0, 7)), 1'b0);
        check("zero_sat", zero_cnt, 8'hFF);
        step("zero_idle", 1'b0, 3'd0, 1'b0);

        // Asynchronous reset in the middle of a hold.
        step("c7_acc", 1'b1, 3'd7, 1'b1);
        step("c7_h1", 1'b0, 3'd0, 1'b0);
        step("c7_h2", 1'b0, 3'd0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 3'd0, 1'b0);

        // Random traffic; a pending sample stays stable until it is accepted.
        pv  = 1'b0;
        pc  = 3'd0;
        pnz = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pv || acc) begin
                pv  = ($urandom_range(0, 2) != 0);
                pc  = 3'($urandom_range(0, 7));
                pnz = ($urandom_range(0, 3) != 0);
            end
            acc = pv && (m_left == 0);
            step("rand", pv, pc, pnz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
